pipelined_csa_tree: RTL and testbench
=====================================

// Module: pipelined_csa_tree
// PURPOSE
//  Reduces NUM_ELEMENTS BIT_LEN-bit terms to two carry-save terms plus their sum, via cascaded 6:3/3:2 levels.
//  Pipeline registers are inserted after every REG_EVERY levels, with a valid/ready handshake and a sideband tag.
//  Sits between partial-product generation and the final carry-propagate adder in the modular squarer datapath.
// PARAMETERS
//  NUM_ELEMENTS  18  input terms per transaction (>=1)
//  BIT_LEN       19  term width; all arithmetic is mod 2^BIT_LEN
//  REG_EVERY     1   reduction levels between pipeline registers (>=1)
//  TAG_WIDTH     8   sideband bits carried alongside data (>=1)
// PORTS
//  clk        in   1                      clock, all logic rising-edge
//  rst        in   1                      synchronous reset, active-high
//  in_valid   in   1                      terms/in_tag valid
//  in_ready   out  1                      stage 0 can accept this cycle
//  terms      in   BIT_LEN x NUM_ELEMENTS unpacked array of input terms
//  in_tag     in   TAG_WIDTH              sideband, travels with terms
//  out_valid  out  1                      out_* valid
//  out_ready  in   1                      downstream accepts this cycle
//  out_a      out  BIT_LEN                carry-save term A
//  out_b      out  BIT_LEN                carry-save term B
//  out_sum    out  BIT_LEN                (out_a + out_b) mod 2^BIT_LEN, combinational from output regs
//  out_tag    out  TAG_WIDTH              tag of the output transaction
// BEHAVIOUR
//  - Level map N->R(N): (N/6)*3 + (N%6>3 ? 3 : N%6>1 ? 2 : N%6).
//    Per group of 6: 6:3 compressor, outputs C4<<2, C2<<1, S. N%6 of 4/5: zero-padded 6:3. N%6 of 3: 3:2 CSA, Cout<<1, S. N%6 of 1/2: pass through.
//  - Levels repeat until N<=2; NUM_LEVELS = count (18->9->5->3->2 gives 4; NUM_ELEMENTS<=2 gives 0). A single final term pads out_b=0.
//  - Shifted carries are truncated to BIT_LEN; MSBs discarded (mod 2^BIT_LEN).
//  - NUM_STAGES = max(1, ceil(NUM_LEVELS/REG_EVERY)). A register follows every REG_EVERY-th level; the last level is always registered.
//  - Latency with out_ready=1: NUM_STAGES cycles from in_valid&in_ready to out_valid.
//  - Each stage k holds data, tag, valid_k. Stage k loads when !valid_k || ready_k; ready_last = out_ready.
//  - in_ready = ready_0, combinational from the stage valids and out_ready.
//  - No bubbles: with out_ready held at 1, throughput is 1 transaction/cycle.
//  - Hold rule: while out_valid & !out_ready, out_a/out_b/out_sum/out_tag stay stable. Upstream stages fill, then in_ready drops.
//  - Transaction accepted when in_valid&in_ready; terms ignored otherwise. Transactions never drop, duplicate or reorder.
//  - out_ready while !out_valid is harmless.
//  - Reset (at any time, including mid-flight): all valid_k cleared next cycle, so out_valid=0; in-flight data discarded.
//    Data/tag regs reset to 0, so out_a=out_b=out_sum=0 and out_tag=0.
//  - in_ready=1 in the first cycle after rst deasserts.
//  - in_valid during rst is ignored.
// TESTING
//  1. Defaults, terms[i]=i+1, tag=8'h5A, out_ready=1 -> out_valid after 4 cycles, out_sum=171, out_tag=8'h5A.
//  2. BIT_LEN=8, 18 terms of 8'hFF -> out_sum = (18*255) mod 256 = 8'hEE; out_a+out_b agrees.
//  3. Back-to-back 10 transactions, tag=i, out_ready=1 -> 10 consecutive out_valid cycles, tags 0..9 in order.
//  4. out_ready=0 for 6 cycles with a stream of 6 transactions -> in_ready falls after 4 accepted; outputs stable.
//     Release out_ready -> all 4 emerge in order; remaining 2 then accepted.
//  5. REG_EVERY=2 -> latency 2; REG_EVERY=8 -> latency 1; NUM_ELEMENTS=1 (term 7) -> out_a=7, out_b=0, latency 1.
//  6. rst pulsed while 3 transactions in flight -> out_valid=0 next cycle, no stale output ever appears.
//     A new transaction then completes with correct sum and 4-cycle latency.
//  Checker: golden model sum of terms mod 2^BIT_LEN on every out_valid&out_ready.
//  Randomise out_ready and in_valid; assert stability under hold and FIFO ordering of tags.

Source files
------------

// File: rtl/pipelined_csa_tree.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipelined_csa_tree
//  Brief    : Carry-save reduction tree (6:3 / 3:2 levels) with a registered
//             valid/ready pipeline and a sideband tag; sums mod 2^BIT_LEN.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_csa_tree #(
    parameter int NUM_ELEMENTS = 18,
    parameter int BIT_LEN      = 19,
    parameter int REG_EVERY    = 1,
    parameter int TAG_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_LEN-1:0]   terms [NUM_ELEMENTS],
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_LEN-1:0]   out_a,
    output logic [BIT_LEN-1:0]   out_b,
    output logic [BIT_LEN-1:0]   out_sum,
    output logic [TAG_WIDTH-1:0] out_tag
);

    typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] vec_t;

    function automatic int level_out(input int n);
        int m;
        m = n % 6;
        return (n / 6) * 3 + ((m > 3) ? 3 : ((m > 1) ? 2 : m));
    endfunction

    function automatic int count_levels(input int n);
        int c;
        int k;
        c = 0;
        k = n;
        while (k > 2) begin
            k = level_out(k);
            c++;
        end
        return c;
    endfunction

    function automatic int terms_at(input int lvl);
        int k;
        k = NUM_ELEMENTS;
        for (int i = 0; i < lvl; i++) k = level_out(k);
        return k;
    endfunction

    // One reduction level: live terms sit in slots [0, n), results are packed
    // from slot 0 upward and every slot beyond the result count is zero.
    function automatic vec_t reduce_level(input vec_t v, input int n);
        vec_t               r;
        logic [BIT_LEN-1:0] x [6];
        logic [BIT_LEN-1:0] s;
        logic [BIT_LEN-1:0] c2;
        logic [BIT_LEN-1:0] c4;
        logic [2:0]         cnt;
        int                 o;
        int                 rem;
        r = '0;
        o = 0;
        for (int g = 0; g < NUM_ELEMENTS; g += 6) begin
            if (g < n) begin
                rem = n - g;
                for (int i = 0; i < 6; i++) begin
                    x[i] = '0;
                    if (g + i < n) x[i] = v[g + i];
                end
                if (rem >= 4) begin
                    for (int b = 0; b < BIT_LEN; b++) begin
                        cnt = '0;
                        for (int i = 0; i < 6; i++) cnt = cnt + 3'(x[i][b]);
                        s[b]  = cnt[0];
                        c2[b] = cnt[1];
                        c4[b] = cnt[2];
                    end
                    r[o]     = s;
                    r[o + 1] = c2 << 1;
                    r[o + 2] = c4 << 2;
                    o += 3;
                end else if (rem == 3) begin
                    r[o]     = x[0] ^ x[1] ^ x[2];
                    r[o + 1] = ((x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2])) << 1;
                    o += 2;
                end else begin
                    r[o] = x[0];
                    if (rem > 1) r[o + 1] = x[1];
                    o += (rem > 1) ? 2 : 1;
                end
            end
        end
        return r;
    endfunction

    localparam int NUM_LEVELS = count_levels(NUM_ELEMENTS);
    localparam int NUM_STAGES = (NUM_LEVELS == 0) ? 1 : (NUM_LEVELS + REG_EVERY - 1) / REG_EVERY;
    localparam int LAST       = NUM_STAGES - 1;

    vec_t terms_vec;
    vec_t final_q;

    always_comb begin
        terms_vec = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) terms_vec[i] = terms[i];
    end

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            vec_t                 src;
            vec_t                 data_d;
            vec_t                 data_q;
            logic                 src_valid;
            logic                 valid_q;
            logic                 ready;
            logic [TAG_WIDTH-1:0] src_tag;
            logic [TAG_WIDTH-1:0] tag_q;

            if (k == 0) begin : g_src_in
                assign src       = terms_vec;
                assign src_valid = in_valid;
                assign src_tag   = in_tag;
            end else begin : g_src_prev
                assign src       = g_stage[k-1].data_q;
                assign src_valid = g_stage[k-1].valid_q;
                assign src_tag   = g_stage[k-1].tag_q;
            end

            if (k == LAST) begin : g_ready_out
                assign ready = !valid_q || out_ready;
            end else begin : g_ready_next
                assign ready = !valid_q || g_stage[k+1].ready;
            end

            for (genvar j = 0; j < REG_EVERY; j++) begin : g_level
                vec_t lvl_in;
                vec_t lvl_out;
                if (j == 0) begin : g_first
                    assign lvl_in = src;
                end else begin : g_chain
                    assign lvl_in = g_level[j-1].lvl_out;
                end
                if (k * REG_EVERY + j < NUM_LEVELS) begin : g_reduce
                    assign lvl_out = reduce_level(lvl_in, terms_at(k * REG_EVERY + j));
                end else begin : g_pass
                    assign lvl_out = lvl_in;
                end
            end

            assign data_d = g_level[REG_EVERY-1].lvl_out;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    tag_q   <= '0;
                end else if (ready) begin
                    valid_q <= src_valid;
                    if (src_valid) begin
                        data_q <= data_d;
                        tag_q  <= src_tag;
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = g_stage[0].ready;
    assign out_valid = g_stage[LAST].valid_q;
    assign out_tag   = g_stage[LAST].tag_q;
    assign final_q   = g_stage[LAST].data_q;
    assign out_a     = final_q[0];

    // Slots past the final term count are zero by construction, so folding
    // them in leaves out_b equal to slot 1 (or zero for a single final term).
    always_comb begin
        out_b = '0;
        for (int i = 1; i < NUM_ELEMENTS; i++) out_b = out_b | final_q[i];
    end

    assign out_sum = out_a + out_b;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csa_tree.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_csa_tree
//  Brief    : Directed + randomised-handshake bench with a tag/sum scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_csa_tree;

    localparam int NE = 18;
    localparam int BL = 19;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BL-1:0] terms [NE];
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BL-1:0] out_a, out_b, out_sum;
    logic [TW-1:0] out_tag;

    logic          b_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [7:0]    b_terms [NE];
    logic [TW-1:0] b_tag = '0, b_out_tag;
    logic [7:0]    b_a, b_b, b_sum;

    logic          n_valid = 1'b0, n_in_ready, n_out_valid, n_out_ready = 1'b1;
    logic [BL-1:0] n_terms [1];
    logic [TW-1:0] n_tag = '0, n_out_tag;
    logic [BL-1:0] n_a, n_b, n_sum;

    always #5 clk = ~clk;

    pipelined_csa_tree u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .terms(terms), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sum(out_sum), .out_tag(out_tag)
    );

    pipelined_csa_tree #(.NUM_ELEMENTS(18), .BIT_LEN(8), .REG_EVERY(2), .TAG_WIDTH(8)) u_b8 (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready),
        .terms(b_terms), .in_tag(b_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_a(b_a), .out_b(b_b), .out_sum(b_sum), .out_tag(b_out_tag)
    );

    pipelined_csa_tree #(.NUM_ELEMENTS(1), .BIT_LEN(19), .REG_EVERY(8), .TAG_WIDTH(8)) u_n1 (
        .clk(clk), .rst(rst), .in_valid(n_valid), .in_ready(n_in_ready),
        .terms(n_terms), .in_tag(n_tag), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_a(n_a), .out_b(n_b), .out_sum(n_sum), .out_tag(n_out_tag)
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [BL-1:0] sum;
    } exp_t;

    exp_t          sb [$];
    int            checks = 0;
    int            errors = 0;
    int            pops = 0;
    int            cyc = 0;
    bit            done = 1'b0;
    logic          hold_q = 1'b0;
    logic [BL-1:0] a_q, b_q;
    logic [TW-1:0] tag_q;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_valid", 64'(out_valid), 1);
                check("hold_a", 64'(out_a), 64'(a_q));
                check("hold_b", 64'(out_b), 64'(b_q));
                check("hold_tag", 64'(out_tag), 64'(tag_q));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 0);
                end else begin
                    check("out_sum", 64'(out_sum), 64'(sb[0].sum));
                    check("a_plus_b", 64'(BL'(out_a + out_b)), 64'(sb[0].sum));
                    check("out_tag", 64'(out_tag), 64'(sb[0].tag));
                    void'(sb.pop_front());
                    pops++;
                end
            end
            hold_q = out_valid && !out_ready;
            a_q    = out_a;
            b_q    = out_b;
            tag_q  = out_tag;
        end
    end

    task automatic send(input logic [TW-1:0] tag, input bit rnd);
        logic [BL-1:0] s;
        bit            ok;
        s  = '0;
        ok = 1'b0;
        for (int i = 0; i < NE; i++) begin
            terms[i] = rnd ? BL'($urandom) : BL'(i + 1);
            s        = s + terms[i];
        end
        in_tag   = tag;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'(in_ready), 1);
        else     sb.push_back({tag, s});
    endtask

    task automatic measure_latency(input string name);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, 64'(lat), 4);
    endtask

    initial begin
        int c0;
        int p0;
        for (int i = 0; i < NE; i++) begin
            terms[i]   = '0;
            b_terms[i] = '0;
        end
        n_terms[0] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_a", 64'(out_a), 0);
        check("rst_out_b", 64'(out_b), 0);
        check("rst_out_sum", 64'(out_sum), 0);
        check("rst_out_tag", 64'(out_tag), 0);
        check("rst_b8_valid", 64'(b_out_valid), 0);
        check("rst_n1_valid", 64'(n_out_valid), 0);
        rst = 1'b0;
        check("in_ready_after_rst", 64'(in_ready), 1);

        // Terms 1..18, tag 5A: four-stage latency, sum 171
        send(8'h5A, 1'b0);
        measure_latency("latency_default");
        check("t1_sum", 64'(out_sum), 171);
        check("t1_tag", 64'(out_tag), 8'h5A);
        @(posedge clk);
        #1;

        // 8-bit / REG_EVERY=2 wraparound and single-term pass-through
        for (int i = 0; i < NE; i++) b_terms[i] = 8'hFF;
        n_terms[0] = 19'd7;
        b_valid    = 1'b1;
        n_valid    = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        n_valid = 1'b0;
        check("b8_not_yet_valid", 64'(b_out_valid), 0);
        check("n1_valid_lat1", 64'(n_out_valid), 1);
        check("n1_out_a", 64'(n_a), 7);
        check("n1_out_b", 64'(n_b), 0);
        check("n1_out_sum", 64'(n_sum), 7);
        @(posedge clk);
        #1;
        check("b8_valid_lat2", 64'(b_out_valid), 1);
        check("b8_out_sum", 64'(b_sum), 8'hEE);
        check("b8_a_plus_b", 64'(8'(b_a + b_b)), 8'hEE);

        // Ten back-to-back transactions with no bubbles
        c0 = cyc;
        p0 = pops;
        for (int i = 0; i < 10; i++) send(TW'(i), 1'b1);
        check("b2b_accept_cycles", 64'(cyc - c0), 10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("b2b_outputs", 64'(pops - p0), 10);

        // Backpressure: four fill the pipe, then input stalls and outputs hold
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(TW'(8'h20 + i), 1'b1);
        check("bp_in_ready_low", 64'(in_ready), 0);
        check("bp_out_valid", 64'(out_valid), 1);
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready_still_low", 64'(in_ready), 0);
        out_ready = 1'b1;
        send(8'h24, 1'b1);
        send(8'h25, 1'b1);

        // Randomised in_valid / out_ready
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    int gap;
                    send(TW'(8'h40 + i), 1'b1);
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("random_drain", 64'(sb.size()), 0);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) send(TW'(8'h70 + i), 1'b1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 0);
        check("midrst_out_a", 64'(out_a), 0);
        check("midrst_out_sum", 64'(out_sum), 0);
        check("midrst_out_tag", 64'(out_tag), 0);
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        send(8'h7F, 1'b1);
        measure_latency("latency_after_rst");
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("final_drain", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
